// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard control unit: FSM state encoding and the
// constant bubble control word / NOP instruction used by the NOP-insertion path.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    LSTALL = 2'd1,
    FLUSH  = 2'd2
  } hz_state_t;

  localparam logic [9:0]  NOP_CTRL  = 10'h000;
  // addi x0, x0, 0 -- what IF/ID holds after a flush
  localparam logic [31:0] NOP_INSTR = 32'h00000013;

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at its maximum value instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg <= '0;
    end else if (inc && (count_reg != {W{1'b1}})) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/hazard_control_unit.sv
// Load-use / taken-branch hazard controller: drives the NOP mux select, PC and
// IF/ID enables, IF/ID flush, and counts stall cycles and taken branches.
module hazard_control_unit
  import hazard_pkg::*;
#(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int FLUSH_CYCLES      = 1,
  parameter int CNT_W             = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       ip_IF_ID_rs1,
  input  logic [4:0]       ip_IF_ID_rs2,
  input  logic             ip_use_rs1,
  input  logic             ip_use_rs2,
  input  logic             ip_ID_EX_MemRead,
  input  logic [4:0]       ip_ID_EX_rd,
  input  logic             ip_branch_taken,
  output logic             op_sel_Hazard_Unit,
  output logic [9:0]       op_NOP_Instruction,
  output logic             op_PC_Write,
  output logic             op_IF_ID_Write,
  output logic             op_IF_ID_Flush,
  output logic [CNT_W-1:0] op_stall_count,
  output logic [CNT_W-1:0] op_flush_count
);

  localparam logic [2:0] LS_REM = 3'(LOAD_STALL_CYCLES - 1);
  localparam logic [2:0] FL_REM = 3'(FLUSH_CYCLES - 1);

  hz_state_t  state_reg, state_next;
  logic [2:0] rem_reg, rem_next;
  logic       lu;
  logic       stall_inc;
  logic       flush_inc;

  assign lu = ip_ID_EX_MemRead && (ip_ID_EX_rd != 5'd0) &&
              ((ip_use_rs1 && (ip_IF_ID_rs1 == ip_ID_EX_rd)) ||
               (ip_use_rs2 && (ip_IF_ID_rs2 == ip_ID_EX_rd)));

  assign op_NOP_Instruction = NOP_CTRL;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= RUN;
      rem_reg   <= 3'd0;
    end else begin
      state_reg <= state_next;
      rem_reg   <= rem_next;
    end
  end

  always_comb begin
    state_next         = state_reg;
    rem_next           = rem_reg;
    op_sel_Hazard_Unit = 1'b0;
    op_PC_Write        = 1'b1;
    op_IF_ID_Write     = 1'b1;
    op_IF_ID_Flush     = 1'b0;
    stall_inc          = 1'b0;
    flush_inc          = 1'b0;

    if (reset) begin
      op_sel_Hazard_Unit = 1'b1;
      op_PC_Write        = 1'b0;
      op_IF_ID_Write     = 1'b0;
      op_IF_ID_Flush     = 1'b1;
      state_next         = RUN;
      rem_next           = 3'd0;
    end else begin
      case (state_reg)
        RUN, LSTALL: begin
          if (ip_branch_taken) begin
            // A taken branch squashes any stall in progress; PC loads the target.
            op_sel_Hazard_Unit = 1'b1;
            op_IF_ID_Flush     = 1'b1;
            flush_inc          = 1'b1;
            if (FLUSH_CYCLES > 1) begin
              state_next = FLUSH;
              rem_next   = FL_REM;
            end else begin
              state_next = RUN;
              rem_next   = 3'd0;
            end
          end else if ((state_reg == LSTALL) || lu) begin
            op_sel_Hazard_Unit = 1'b1;
            op_PC_Write        = 1'b0;
            op_IF_ID_Write     = 1'b0;
            stall_inc          = 1'b1;
            if (state_reg == LSTALL) begin
              rem_next = rem_reg - 3'd1;
              if (rem_reg == 3'd1) begin
                state_next = RUN;
              end
            end else if (LOAD_STALL_CYCLES > 1) begin
              state_next = LSTALL;
              rem_next   = LS_REM;
            end
          end
        end
        FLUSH: begin
          // Branches seen here come from squashed instructions and are ignored.
          op_sel_Hazard_Unit = 1'b1;
          op_IF_ID_Flush     = 1'b1;
          rem_next           = rem_reg - 3'd1;
          if (rem_reg == 3'd1) begin
            state_next = RUN;
          end
        end
        default: begin
          state_next = RUN;
          rem_next   = 3'd0;
        end
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_counter (
    .clk   (clk),
    .reset (reset),
    .inc   (stall_inc),
    .count (op_stall_count)
  );

  sat_counter #(.W(CNT_W)) u_flush_counter (
    .clk   (clk),
    .reset (reset),
    .inc   (flush_inc),
    .count (op_flush_count)
  );

endmodule

// File: tb/tb_hazard_control_unit.sv
// Drives three differently parameterised hazard units with shared stimulus and
// checks every cycle against a counter-based reference model of the rules.
module tb_hazard_control_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] rs1, rs2, rd;
  logic       use1, use2, mr, br;

  always #5 clk = ~clk;

  // instance 0: L=1 F=1 W=16; instance 1: L=2 F=2 W=16; instance 2: L=3 F=2 W=4
  int P_L   [3] = '{1, 2, 3};
  int P_F   [3] = '{1, 2, 2};
  int P_MAX [3] = '{65535, 65535, 15};

  int m_sl [3];
  int m_fl [3];
  int m_sc [3];
  int m_fc [3];

  int n_cmp  = 0;
  int n_fail = 0;

  logic        sel_a, pcw_a, ifw_a, fl_a;
  logic [9:0]  nop_a;
  logic [15:0] sc_a, fc_a;
  logic        sel_b, pcw_b, ifw_b, fl_b;
  logic [9:0]  nop_b;
  logic [15:0] sc_b, fc_b;
  logic        sel_c, pcw_c, ifw_c, fl_c;
  logic [9:0]  nop_c;
  logic [3:0]  sc_c, fc_c;

  // {nop[45:36], sel/pcw/ifw/flush[35:32], stall_count[31:16], flush_count[15:0]}
  logic [45:0] obs [3];
  assign obs[0] = {nop_a, sel_a, pcw_a, ifw_a, fl_a, sc_a, fc_a};
  assign obs[1] = {nop_b, sel_b, pcw_b, ifw_b, fl_b, sc_b, fc_b};
  assign obs[2] = {nop_c, sel_c, pcw_c, ifw_c, fl_c, 12'd0, sc_c, 12'd0, fc_c};

  hazard_control_unit #(.LOAD_STALL_CYCLES(1), .FLUSH_CYCLES(1), .CNT_W(16)) dut_a (
    .clk(clk), .reset(reset), .ip_IF_ID_rs1(rs1), .ip_IF_ID_rs2(rs2),
    .ip_use_rs1(use1), .ip_use_rs2(use2), .ip_ID_EX_MemRead(mr), .ip_ID_EX_rd(rd),
    .ip_branch_taken(br), .op_sel_Hazard_Unit(sel_a), .op_NOP_Instruction(nop_a),
    .op_PC_Write(pcw_a), .op_IF_ID_Write(ifw_a), .op_IF_ID_Flush(fl_a),
    .op_stall_count(sc_a), .op_flush_count(fc_a)
  );

  hazard_control_unit #(.LOAD_STALL_CYCLES(2), .FLUSH_CYCLES(2), .CNT_W(16)) dut_b (
    .clk(clk), .reset(reset), .ip_IF_ID_rs1(rs1), .ip_IF_ID_rs2(rs2),
    .ip_use_rs1(use1), .ip_use_rs2(use2), .ip_ID_EX_MemRead(mr), .ip_ID_EX_rd(rd),
    .ip_branch_taken(br), .op_sel_Hazard_Unit(sel_b), .op_NOP_Instruction(nop_b),
    .op_PC_Write(pcw_b), .op_IF_ID_Write(ifw_b), .op_IF_ID_Flush(fl_b),
    .op_stall_count(sc_b), .op_flush_count(fc_b)
  );

  hazard_control_unit #(.LOAD_STALL_CYCLES(3), .FLUSH_CYCLES(2), .CNT_W(4)) dut_c (
    .clk(clk), .reset(reset), .ip_IF_ID_rs1(rs1), .ip_IF_ID_rs2(rs2),
    .ip_use_rs1(use1), .ip_use_rs2(use2), .ip_ID_EX_MemRead(mr), .ip_ID_EX_rd(rd),
    .ip_branch_taken(br), .op_sel_Hazard_Unit(sel_c), .op_NOP_Instruction(nop_c),
    .op_PC_Write(pcw_c), .op_IF_ID_Write(ifw_c), .op_IF_ID_Flush(fl_c),
    .op_stall_count(sc_c), .op_flush_count(fc_c)
  );

  // ---------------- reference model ----------------
  function automatic bit lu_now();
    return mr && (rd != 5'd0) && ((use1 && rs1 == rd) || (use2 && rs2 == rd));
  endfunction

  // Output pattern bits are {sel, PC_Write, IF_ID_Write, IF_ID_Flush}.
  function automatic logic [45:0] exp_all(int k);
    logic [3:0] p;
    if (reset)                          p = 4'b1001;
    else if (m_fl[k] > 0 || br)         p = 4'b1111;
    else if (m_sl[k] > 0 || lu_now())   p = 4'b1000;
    else                                p = 4'b0110;
    return {10'h000, p, 16'(m_sc[k]), 16'(m_fc[k])};
  endfunction

  task automatic model_commit(int k);
    if (reset) begin
      m_sl[k] = 0; m_fl[k] = 0; m_sc[k] = 0; m_fc[k] = 0;
    end else if (m_fl[k] > 0) begin
      m_fl[k]--;
    end else if (br) begin
      if (m_fc[k] < P_MAX[k]) m_fc[k]++;
      m_fl[k] = P_F[k] - 1;
      m_sl[k] = 0;
    end else if (m_sl[k] > 0 || lu_now()) begin
      if (m_sc[k] < P_MAX[k]) m_sc[k]++;
      if (m_sl[k] > 0) m_sl[k]--;
      else m_sl[k] = P_L[k] - 1;
    end
  endtask

  task automatic advance();
    @(posedge clk);
    for (int k = 0; k < 3; k++) model_commit(k);
    #1;
  endtask

  task automatic drive(input logic r, input logic b, input logic m, input logic [4:0] d,
                       input logic [4:0] s1, input logic u1, input logic [4:0] s2, input logic u2);
    reset = r; br = b; mr = m; rd = d; rs1 = s1; use1 = u1; rs2 = s2; use2 = u2;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [45:0] e;
    drive(1'b1, 1'b0, 1'b1, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
    advance();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      $display("[%0t] reset cyc%0d pats %b %b %b", $time, c, obs[0][35:32], obs[1][35:32], obs[2][35:32]);
      for (int k = 0; k < 3; k++) begin
        e = exp_all(k);
        n_cmp++;
        if (obs[k] !== e) begin
          n_fail++;
          $display("FAIL reset inst%0d got nop=%h pat=%b sc=%0d fc=%0d want nop=%h pat=%b sc=%0d fc=%0d",
                   k, obs[k][45:36], obs[k][35:32], obs[k][31:16], obs[k][15:0], e[45:36], e[35:32], e[31:16], e[15:0]);
        end
      end
      advance();
    end
  endtask

  task automatic test_load_use();
    logic [45:0] e;
    // lw x5 in EX, add reading x5 via rs1 in ID, then released
    for (int c = 0; c < 4; c++) begin
      if (c == 0) drive(1'b0, 1'b0, 1'b1, 5'd5, 5'd5, 1'b1, 5'd3, 1'b1);
      else idle();
      @(negedge clk);
      $display("[%0t] load_use cyc%0d pats %b %b %b", $time, c, obs[0][35:32], obs[1][35:32], obs[2][35:32]);
      for (int k = 0; k < 3; k++) begin
        e = exp_all(k);
        n_cmp++;
        if (obs[k] !== e) begin
          n_fail++;
          $display("FAIL load_use inst%0d got pat=%b sc=%0d fc=%0d want pat=%b sc=%0d fc=%0d",
                   k, obs[k][35:32], obs[k][31:16], obs[k][15:0], e[35:32], e[31:16], e[15:0]);
        end
      end
      n_cmp++;
      if (c == 1 && obs[0][35:0] !== {4'b0110, 16'd1, 16'd0}) begin
        n_fail++;
        $display("FAIL load_use_release inst0 got pat=%b sc=%0d want pat=0110 sc=1", obs[0][35:32], obs[0][31:16]);
      end
      advance();
    end
  endtask

  task automatic test_x0_unused();
    logic [45:0] e;
    for (int c = 0; c < 3; c++) begin
      case (c)
        0: drive(1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1);   // load into x0
        1: drive(1'b0, 1'b0, 1'b1, 5'd7, 5'd1, 1'b1, 5'd7, 1'b0);   // rs2 match but unused
        default: drive(1'b0, 1'b0, 1'b1, 5'd7, 5'd7, 1'b1, 5'd7, 1'b1); // both match
      endcase
      @(negedge clk);
      $display("[%0t] x0_unused cyc%0d pats %b %b %b", $time, c, obs[0][35:32], obs[1][35:32], obs[2][35:32]);
      for (int k = 0; k < 3; k++) begin
        e = exp_all(k);
        n_cmp++;
        if (obs[k] !== e) begin
          n_fail++;
          $display("FAIL x0_unused inst%0d got pat=%b sc=%0d want pat=%b sc=%0d",
                   k, obs[k][35:32], obs[k][31:16], e[35:32], e[31:16]);
        end
      end
      advance();
    end
    idle();
    for (int c = 0; c < 4; c++) advance();
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (obs[k][31:16] !== 16'(m_sc[k])) begin
        n_fail++;
        $display("FAIL x0_unused_drain inst%0d got sc=%0d want sc=%0d", k, obs[k][31:16], m_sc[k]);
      end
    end
  endtask

  task automatic test_multicycle_and_branch();
    logic [45:0] e;
    // hazard, idle; branch+hazard together; branch in stall; back-to-back branches
    logic [1:0] seq [10] = '{2'd1, 2'd0, 2'd0, 2'd0, 2'd3, 2'd0, 2'd1, 2'd2, 2'd2, 2'd2};
    for (int c = 0; c < 10; c++) begin
      drive(1'b0, seq[c][1], seq[c][0], 5'd9, 5'd9, seq[c][0], 5'd0, 1'b0);
      @(negedge clk);
      $display("[%0t] stall_branch cyc%0d br=%b lu=%b pats %b %b %b", $time, c, br, lu_now(),
               obs[0][35:32], obs[1][35:32], obs[2][35:32]);
      for (int k = 0; k < 3; k++) begin
        e = exp_all(k);
        n_cmp++;
        if (obs[k] !== e) begin
          n_fail++;
          $display("FAIL stall_branch inst%0d cyc%0d got pat=%b sc=%0d fc=%0d want pat=%b sc=%0d fc=%0d",
                   k, c, obs[k][35:32], obs[k][31:16], obs[k][15:0], e[35:32], e[31:16], e[15:0]);
        end
      end
      advance();
    end
  endtask

  task automatic test_reset_mid_stall();
    logic [45:0] e;
    for (int c = 0; c < 5; c++) begin
      case (c)
        0: drive(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        1: drive(1'b0, 1'b0, 1'b1, 5'd4, 5'd0, 1'b0, 5'd4, 1'b1);
        2: drive(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        default: idle();
      endcase
      @(negedge clk);
      $display("[%0t] reset_mid cyc%0d pats %b %b %b", $time, c, obs[0][35:32], obs[1][35:32], obs[2][35:32]);
      for (int k = 0; k < 3; k++) begin
        e = exp_all(k);
        n_cmp++;
        if (obs[k] !== e) begin
          n_fail++;
          $display("FAIL reset_mid inst%0d cyc%0d got pat=%b sc=%0d want pat=%b sc=%0d",
                   k, c, obs[k][35:32], obs[k][31:16], e[35:32], e[31:16]);
        end
      end
      n_cmp++;
      if (c == 3 && obs[2][35:0] !== {4'b0110, 16'd0, 16'd0}) begin
        n_fail++;
        $display("FAIL reset_mid_residual inst2 got pat=%b sc=%0d want pat=0110 sc=0", obs[2][35:32], obs[2][31:16]);
      end
      advance();
    end
  endtask

  task automatic test_saturation();
    logic [45:0] e;
    for (int c = 0; c < 80; c++) begin
      if (c % 4 == 0) drive(1'b0, 1'b0, 1'b1, 5'd6, 5'd6, 1'b1, 5'd6, 1'b1);
      else idle();
      @(negedge clk);
      $display("[%0t] saturation cyc%0d sc %0d %0d %0d", $time, c, obs[0][31:16], obs[1][31:16], obs[2][31:16]);
      for (int k = 0; k < 3; k++) begin
        e = exp_all(k);
        n_cmp++;
        if (obs[k] !== e) begin
          n_fail++;
          $display("FAIL saturation inst%0d cyc%0d got pat=%b sc=%0d want pat=%b sc=%0d",
                   k, c, obs[k][35:32], obs[k][31:16], e[35:32], e[31:16]);
        end
      end
      advance();
    end
    @(negedge clk);
    n_cmp++;
    if (obs[2][31:16] !== 16'd15 || obs[0][31:16] !== 16'd20) begin
      n_fail++;
      $display("FAIL saturation_final got inst0 sc=%0d inst2 sc=%0d want 20 and 15", obs[0][31:16], obs[2][31:16]);
    end
  endtask

  task automatic test_random();
    logic [45:0] e;
    for (int c = 0; c < 400; c++) begin
      drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 6) == 0), $urandom_range(0, 1),
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), $urandom_range(0, 1),
            5'($urandom_range(0, 3)), $urandom_range(0, 1));
      @(negedge clk);
      $display("[%0t] random cyc%0d r=%b br=%b lu=%b pats %b %b %b", $time, c, reset, br, lu_now(),
               obs[0][35:32], obs[1][35:32], obs[2][35:32]);
      for (int k = 0; k < 3; k++) begin
        e = exp_all(k);
        n_cmp++;
        if (obs[k] !== e) begin
          n_fail++;
          $display("FAIL random inst%0d cyc%0d got pat=%b sc=%0d fc=%0d want pat=%b sc=%0d fc=%0d",
                   k, c, obs[k][35:32], obs[k][31:16], obs[k][15:0], e[35:32], e[31:16], e[15:0]);
        end
      end
      advance();
    end
  endtask

  initial begin
    drive(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      m_sl[k] = 0; m_fl[k] = 0; m_sc[k] = 0; m_fc[k] = 0;
    end
    test_reset();
    test_load_use();
    test_x0_unused();
    test_multicycle_and_branch();
    test_reset_mid_stall();
    test_saturation();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
